// File: rtl/serial_pkg.sv
// serial_pkg: shared types and sizing helpers for the serial link blocks
package serial_pkg;
  localparam int DEF_WIDTH = 8;
  typedef enum logic {RX_IDLE, RX_SHIFT} rx_state_t;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/rx_shift_reg.sv
// rx_shift_reg: WIDTH-bit serial-in shift register with clear and shift enable
module rx_shift_reg import serial_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] nxt
);
  logic [WIDTH-1:0] q, base;
  always_comb begin
    base = clr ? '0 : q;
    nxt = LSB_FIRST ? {bit_in, base[WIDTH-1:1]} : {base[WIDTH-2:0], bit_in};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (clr | en) q <= en ? nxt : base;
endmodule

// File: rtl/serial_rx_8.sv
// serial_rx_8: serial-in/parallel-out frame receiver with a one-entry valid/ready holding register
module serial_rx_8 import serial_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      Start,
  input  logic                      Bit_In,
  input  logic                      Bit_Valid,
  input  logic                      Data_Ready,
  input  logic                      Clear_Overrun,
  output logic [WIDTH-1:0]          Data_Out,
  output logic                      Data_Valid,
  output logic                      Overrun,
  output logic                      Busy,
  output logic [cnt_w(WIDTH)-1:0]   Bit_Count
);
  localparam int CW = cnt_w(WIDTH);
  rx_state_t state, state_n;
  logic [CW-1:0] idx, cnt_n;
  logic [WIDTH-1:0] word;
  logic acc, done;
  rx_shift_reg #(.WIDTH(WIDTH), .LSB_FIRST(LSB_FIRST)) u_sr (
    .clk(Clk), .rst(Reset), .clr(Start), .en(acc), .bit_in(Bit_In), .nxt(word)
  );
  // Start restarts the bit index, so a bit arriving with Start is always bit 0
  always_comb begin
    acc = Bit_Valid & (Start | state == RX_SHIFT);
    idx = Start ? '0 : Bit_Count;
    done = acc & (idx == CW'(WIDTH - 1));
    cnt_n = done ? '0 : acc ? CW'(idx + 1'b1) : idx;
    state_n = done ? RX_IDLE : Start ? RX_SHIFT : state;
  end
  assign Busy = state == RX_SHIFT;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) state <= RX_IDLE;
    else state <= state_n;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      Bit_Count <= '0;
      Data_Out <= '0;
      Data_Valid <= 1'b0;
      Overrun <= 1'b0;
    end else begin
      Bit_Count <= cnt_n;
      Data_Valid <= done | (Data_Valid & ~Data_Ready);
      Overrun <= (done & Data_Valid & ~Data_Ready) | (Overrun & ~Clear_Overrun);
      if (done) Data_Out <= word;
    end
endmodule

// File: tb/tb_serial_rx_8.sv
// tb_serial_rx_8: scoreboard bench driving LSB-first and MSB-first receivers with the same bit stream
module tb_serial_rx_8;
  localparam int W = 8;
  logic clk = 1'b0, rst, st, bi, bv, rdy, clr;
  logic [W-1:0] dl, dm;
  logic vl, vm, ol, om, bl, bm;
  logic [3:0] cl, cm;
  int total = 0, bad = 0, rises = 0, r0;
  logic [W-1:0] exp_l[$], exp_m[$];
  bit bits[$];
  bit act = 0, mv = 0, mo = 0, done, ovw;
  logic [W-1:0] wl, wm, w;

  serial_rx_8 #(.WIDTH(W), .LSB_FIRST(1'b1)) u_l (
    .Clk(clk), .Reset(rst), .Start(st), .Bit_In(bi), .Bit_Valid(bv), .Data_Ready(rdy),
    .Clear_Overrun(clr), .Data_Out(dl), .Data_Valid(vl), .Overrun(ol), .Busy(bl), .Bit_Count(cl)
  );
  serial_rx_8 #(.WIDTH(W), .LSB_FIRST(1'b0)) u_m (
    .Clk(clk), .Reset(rst), .Start(st), .Bit_In(bi), .Bit_Valid(bv), .Data_Ready(rdy),
    .Clear_Overrun(clr), .Data_Out(dm), .Data_Valid(vm), .Overrun(om), .Busy(bm), .Bit_Count(cm)
  );

  always #5 clk = ~clk;
  always @(posedge vl) rises++;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  // Reference model: evaluated before each rising edge from the inputs about to be sampled
  always @(negedge clk) begin
    if (rst) begin
      bits.delete(); act = 0; mv = 0; mo = 0;
      exp_l.delete(); exp_m.delete();
    end else begin
      chk("busy", bl, act); chk("busy_m", bm, act);
      chk("count", cl, bits.size()); chk("count_m", cm, bits.size());
      chk("valid", vl, mv); chk("valid_m", vm, mv);
      chk("overrun", ol, mo); chk("overrun_m", om, mo);
      if (st) begin bits.delete(); act = 1; end
      done = 0;
      if (bv && act) begin
        bits.push_back(bi);
        done = bits.size() == W;
      end
      ovw = done && mv && !rdy;
      if (done) begin
        wl = '0; wm = '0;
        foreach (bits[i]) begin wl[i] = bits[i]; wm[W-1-i] = bits[i]; end
        if (ovw && exp_l.size() > 0) begin
          exp_l[exp_l.size()-1] = wl; exp_m[exp_m.size()-1] = wm;
        end else begin
          exp_l.push_back(wl); exp_m.push_back(wm);
        end
        mv = 1; bits.delete(); act = 0;
      end else if (mv && rdy) mv = 0;
      mo = ovw || (mo && !clr);
    end
  end

  // Monitor: compares the held word whenever the consumer takes it
  always @(negedge clk)
    if (!rst && vl && rdy) begin
      if (exp_l.size() == 0) chk("sb_empty", exp_l.size(), 1);
      else begin
        chk("word_lsb", dl, exp_l.pop_front());
        chk("word_msb", dm, exp_m.pop_front());
      end
    end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic frame(input logic [W-1:0] fw, input int gap, input bit sv, input bit rl);
    st = 1; bv = sv; bi = fw[0];
    tick;
    st = 0;
    for (int i = int'(sv); i < W; i++) begin
      bi = fw[i]; bv = 1;
      if (i == W - 1 && rl) rdy = 1;
      tick;
      bv = 0;
      if (rl) rdy = 0;
      repeat (gap) tick;
    end
  endtask

  task automatic consume;
    rdy = 1; tick; rdy = 0;
  endtask

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    rst = 1; st = 0; bi = 0; bv = 0; rdy = 0; clr = 0;
    repeat (2) tick;
    chk("rst_dout", dl, 0); chk("rst_valid", vl, 0); chk("rst_ovr", ol, 0);
    chk("rst_busy", bl, 0); chk("rst_count", cl, 0);
    rst = 0; tick;
    frame(8'hA5, 0, 0, 0);
    chk("t1_lsb", dl, 8'hA5); chk("t1_msb", dm, 8'hA5);
    chk("t1_valid", vl, 1); chk("t1_busy", bl, 0); chk("t1_ovr", ol, 0);
    consume;
    frame(8'h3C, 2, 0, 0);
    chk("t2_lsb", dl, 8'h3C); chk("t2_msb", dm, 8'h3C);
    consume;
    frame(8'h11, 0, 0, 0);
    frame(8'h22, 0, 0, 0);
    chk("t3_dout", dl, 8'h22); chk("t3_valid", vl, 1); chk("t3_ovr", ol, 1);
    clr = 1; tick; clr = 0;
    chk("t3_clr", ol, 0); chk("t3_valid_kept", vl, 1);
    frame(8'h66, 0, 0, 0);
    clr = 1; tick; clr = 0;
    frame(8'h77, 0, 0, 1);
    chk("t4_dout", dl, 8'h77); chk("t4_valid", vl, 1); chk("t4_ovr", ol, 0);
    consume;
    r0 = rises;
    st = 1; tick; st = 0;
    for (int i = 0; i < 3; i++) begin bi = 1'($urandom); bv = 1; tick; end
    bv = 0;
    frame(8'h5A, 0, 0, 0);
    chk("t5_dout", dl, 8'h5A); chk("t5_rises", rises - r0, 1);
    consume;
    frame(8'h99, 0, 0, 0);
    st = 1; tick; st = 0;
    for (int i = 0; i < 5; i++) begin bi = 1'($urandom); bv = 1; tick; end
    bv = 0;
    chk("t6_count", cl, 5); chk("t6_valid", vl, 1);
    #2 rst = 1;
    #1;
    chk("t6_dout", dl, 0); chk("t6_valid0", vl, 0); chk("t6_busy", bl, 0);
    chk("t6_count0", cl, 0); chk("t6_msb0", dm, 0);
    tick; rst = 0; tick;
    frame(8'hC3, 1, 1, 0);
    chk("t6_c3", dl, 8'hC3);
    consume;
    repeat (40) begin
      w = W'($urandom);
      rdy = 1'($urandom_range(0, 1));
      clr = $urandom_range(0, 3) == 0;
      frame(w, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0);
      chk("rand_lsb", dl, w);
    end
    clr = 0;
    consume;
    tick;
    chk("drain", exp_l.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
